// File: rtl/sent_crc_engine.sv
// sent_crc_engine
// Streaming CRC engine for the SENT receive path. One CRC_W-bit chunk is
// folded into the running remainder per cycle. The engine tracks frame
// boundaries and chunk count, and optionally appends one zero chunk
// (recommended/augmented mode). It then reports the final CRC together with
// a match flag against the CRC the decoder received.
// Instances: CRC4 fast channel (POLY=4'hD, SEED=4'h5) and
//            CRC6 serial message (POLY=6'h19, SEED=6'h15).
// CRC_W is only meaningful as 4 or 6.

module sent_crc_engine #(
    parameter int               CRC_W      = 4,
    parameter logic [CRC_W-1:0] POLY       = 4'hD,
    parameter logic [CRC_W-1:0] SEED       = 4'h5,
    parameter int               MAX_CHUNKS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din_valid,
    input  logic             din_sop,
    input  logic             din_eop,
    input  logic [CRC_W-1:0] din,
    input  logic             augment,
    input  logic [CRC_W-1:0] rx_crc,
    output logic             busy,
    output logic             crc_valid,
    output logic [CRC_W-1:0] crc_out,
    output logic             crc_match,
    output logic             crc_len_err,
    output logic             err_sync
);

    localparam int               CNT_W   = $clog2(MAX_CHUNKS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CHUNKS);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_CHUNKS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        AUG   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Multiply the remainder by x^CRC_W modulo the generator: CRC_W
    // single-bit shifts, folding the polynomial in whenever the MSB drops out.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c);
        logic [CRC_W-1:0] r;
        r = c;
        for (int i = 0; i < CRC_W; i++) begin
            if (r[CRC_W-1]) begin
                r = {r[CRC_W-2:0], 1'b0} ^ POLY;
            end else begin
                r = {r[CRC_W-2:0], 1'b0};
            end
        end
        return r;
    endfunction

    // Saturating chunk counter increment; saturation at MAX_CHUNKS+1 is
    // enough to flag an over-length frame without wrapping back to legal.
    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] n);
        logic [CNT_W-1:0] r;
        if (n == CNT_SAT) begin
            r = n;
        end else begin
            r = n + CNT_ONE;
        end
        return r;
    endfunction

    state_t           state_q,       state_d;
    logic [CRC_W-1:0] crc_q,         crc_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic             aug_q,         aug_d;
    logic [CRC_W-1:0] rx_crc_q,      rx_crc_d;
    logic             busy_q,        busy_d;
    logic             crc_valid_q,   crc_valid_d;
    logic [CRC_W-1:0] crc_out_q,     crc_out_d;
    logic             crc_match_q,   crc_match_d;
    logic             crc_len_err_q, crc_len_err_d;
    logic             err_sync_q,    err_sync_d;
    logic             sop_beat_s;

    assign sop_beat_s = din_valid & din_sop;

    // Next-state, remainder, counter and output computation for one beat.
    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        cnt_d         = cnt_q;
        aug_d         = aug_q;
        rx_crc_d      = rx_crc_q;
        crc_valid_d   = 1'b0;
        err_sync_d    = 1'b0;
        crc_out_d     = crc_out_q;
        crc_match_d   = crc_match_q;
        crc_len_err_d = crc_len_err_q;

        if (sop_beat_s) begin
            // A sop restarts the frame from any state; whatever was in
            // flight is abandoned and never reported.
            crc_d = crc_step(SEED) ^ din;
            cnt_d = CNT_ONE;
            aug_d = augment;
            if (din_eop) begin
                rx_crc_d = rx_crc;
                state_d  = augment ? AUG : DONE;
            end else begin
                state_d  = ACCUM;
            end
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    // No frame is open: a data beat here is out of sync.
                    err_sync_d = din_valid;
                    state_d    = IDLE;
                end
                ACCUM: begin
                    if (din_valid) begin
                        crc_d = crc_step(crc_q) ^ din;
                        cnt_d = cnt_inc(cnt_q);
                        if (din_eop) begin
                            rx_crc_d = rx_crc;
                            state_d  = aug_q ? AUG : DONE;
                        end else begin
                            state_d  = ACCUM;
                        end
                    end else begin
                        state_d = ACCUM;
                    end
                end
                AUG: begin
                    // Appended zero chunk: the shift alone, nothing XORed in.
                    crc_d   = crc_step(crc_q);
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // Results are latched on entry to DONE so they are visible, with
        // crc_valid, during the DONE cycle itself.
        if (state_d == DONE) begin
            crc_valid_d   = 1'b1;
            crc_out_d     = crc_d;
            crc_match_d   = (crc_d == rx_crc_d);
            crc_len_err_d = (cnt_d > CNT_MAX);
        end else begin
            crc_valid_d   = 1'b0;
        end

        busy_d = (state_d == ACCUM) || (state_d == AUG);
    end

    // State and registered outputs; reset discards any frame in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            crc_q         <= SEED;
            cnt_q         <= {CNT_W{1'b0}};
            aug_q         <= 1'b0;
            rx_crc_q      <= {CRC_W{1'b0}};
            busy_q        <= 1'b0;
            crc_valid_q   <= 1'b0;
            crc_out_q     <= {CRC_W{1'b0}};
            crc_match_q   <= 1'b0;
            crc_len_err_q <= 1'b0;
            err_sync_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            crc_q         <= crc_d;
            cnt_q         <= cnt_d;
            aug_q         <= aug_d;
            rx_crc_q      <= rx_crc_d;
            busy_q        <= busy_d;
            crc_valid_q   <= crc_valid_d;
            crc_out_q     <= crc_out_d;
            crc_match_q   <= crc_match_d;
            crc_len_err_q <= crc_len_err_d;
            err_sync_q    <= err_sync_d;
        end
    end

    assign busy        = busy_q;
    assign crc_valid   = crc_valid_q;
    assign crc_out     = crc_out_q;
    assign crc_match   = crc_match_q;
    assign crc_len_err = crc_len_err_q;
    assign err_sync    = err_sync_q;

endmodule

// File: tb/tb_sent_crc_engine.sv
// Testbench for sent_crc_engine: a CRC4 and a CRC6 instance, scoreboard of
// expected results checked whenever crc_valid pulses, plus directed checks
// of busy, err_sync and reset behaviour.

module tb_sent_crc_engine;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // CRC4 instance signals
    logic       v4, sop4, eop4, aug4;
    logic [3:0] din4, rx4;
    logic       busy4, cv4, cm4, le4, es4;
    logic [3:0] co4;

    // CRC6 instance signals
    logic       v6, sop6, eop6, aug6;
    logic [5:0] din6, rx6;
    logic       busy6, cv6, cm6, le6, es6;
    logic [5:0] co6;

    sent_crc_engine #(.CRC_W(4), .POLY(4'hD), .SEED(4'h5), .MAX_CHUNKS(8)) u_crc4 (
        .clk(clk), .reset(reset), .din_valid(v4), .din_sop(sop4), .din_eop(eop4),
        .din(din4), .augment(aug4), .rx_crc(rx4), .busy(busy4), .crc_valid(cv4),
        .crc_out(co4), .crc_match(cm4), .crc_len_err(le4), .err_sync(es4)
    );

    sent_crc_engine #(.CRC_W(6), .POLY(6'h19), .SEED(6'h15), .MAX_CHUNKS(8)) u_crc6 (
        .clk(clk), .reset(reset), .din_valid(v6), .din_sop(sop6), .din_eop(eop6),
        .din(din6), .augment(aug6), .rx_crc(rx6), .busy(busy6), .crc_valid(cv6),
        .crc_out(co6), .crc_match(cm6), .crc_len_err(le6), .err_sync(es6)
    );

    typedef struct {
        logic [5:0] crc;
        logic       match;
        logic       len_err;
        int         due;
    } exp_t;

    exp_t       sb4[$];
    exp_t       sb6[$];
    exp_t       e4, e6;
    logic [5:0] frm[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Plain long division, one message bit at a time, register starts at 0.
    function automatic logic [5:0] div_word(input logic [5:0] r_in, input logic [5:0] word,
                                            input int w, input logic [5:0] poly);
        logic [5:0] r;
        logic       top;
        r = r_in;
        for (int b = w - 1; b >= 0; b--) begin
            top = r[w-1];
            r   = ((r << 1) | {5'd0, word[b]}) & 6'((1 << w) - 1);
            if (top) r = r ^ poly;
        end
        return r;
    endfunction

    // Message = seed, then every chunk of frm, then a zero chunk if augmented.
    function automatic logic [5:0] ref_crc(input int w, input logic [5:0] poly,
                                           input logic [5:0] seed, input bit aug);
        logic [5:0] r;
        r = div_word(6'd0, seed, w, poly);
        foreach (frm[i]) r = div_word(r, frm[i], w, poly);
        if (aug) r = div_word(r, 6'd0, w, poly);
        return r;
    endfunction

    // Scoreboard: every crc_valid pulse must match the oldest pending frame.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (cv4 === 1'b1) begin
            if (sb4.size() == 0) begin
                chk_eq("c4_spurious_valid", 32'd1, 32'd0);
            end else begin
                e4 = sb4.pop_front();
                chk_eq("c4_crc", {28'd0, co4}, {26'd0, e4.crc});
                chk_eq("c4_match", {31'd0, cm4}, {31'd0, e4.match});
                chk_eq("c4_len_err", {31'd0, le4}, {31'd0, e4.len_err});
                chk_eq("c4_latency", cyc, e4.due);
            end
        end
        if (cv6 === 1'b1) begin
            if (sb6.size() == 0) begin
                chk_eq("c6_spurious_valid", 32'd1, 32'd0);
            end else begin
                e6 = sb6.pop_front();
                chk_eq("c6_crc", {26'd0, co6}, {26'd0, e6.crc});
                chk_eq("c6_match", {31'd0, cm6}, {31'd0, e6.match});
                chk_eq("c6_len_err", {31'd0, le6}, {31'd0, e6.len_err});
                chk_eq("c6_latency", cyc, e6.due);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v4 = 1'b0; sop4 = 1'b0; eop4 = 1'b0;
            v6 = 1'b0; sop6 = 1'b0; eop6 = 1'b0;
        end
    endtask

    // Drive frm as back-to-back beats. augment/rx_crc are inverted on beats
    // where they must be ignored. close=0 leaves the frame open (no eop).
    task automatic send(input bit six, input bit aug, input logic [5:0] rx, input bit close,
                        input bit use_model, input logic [5:0] exp_c);
        exp_t       e;
        int         last;
        logic [5:0] c;
        last = frm.size() - 1;
        for (int i = 0; i <= last; i++) begin
            @(negedge clk);
            if (six) begin
                v6 = 1'b1; sop6 = (i == 0); eop6 = close && (i == last);
                din6 = frm[i]; aug6 = (i == 0) ? aug : ~aug;
                rx6 = (i == last) ? rx : ~rx;
            end else begin
                v4 = 1'b1; sop4 = (i == 0); eop4 = close && (i == last);
                din4 = frm[i][3:0]; aug4 = (i == 0) ? aug : ~aug;
                rx4 = (i == last) ? rx[3:0] : ~rx[3:0];
            end
        end
        if (close) begin
            if (use_model) begin
                c = six ? ref_crc(6, 6'h19, 6'h15, aug) : ref_crc(4, 6'h0D, 6'h05, aug);
            end else begin
                c = exp_c;
            end
            e.crc     = c;
            e.match   = six ? (c == rx) : (c[3:0] == rx[3:0]);
            e.len_err = (frm.size() > 8);
            e.due     = cyc + 1 + (aug ? 1 : 0);
            if (six) sb6.push_back(e);
            else     sb4.push_back(e);
        end
    endtask

    task automatic rand_frame(input int n, input int w);
        frm.delete();
        for (int i = 0; i < n; i++) frm.push_back(6'($urandom_range((1 << w) - 1, 0)));
    endtask

    initial begin
        reset = 1'b1;
        v4 = 1'b0; sop4 = 1'b0; eop4 = 1'b0; din4 = 4'd0; aug4 = 1'b0; rx4 = 4'd0;
        v6 = 1'b0; sop6 = 1'b0; eop6 = 1'b0; din6 = 6'd0; aug6 = 1'b0; rx6 = 6'd0;
        repeat (3) @(negedge clk);
        chk_eq("rst_busy", {31'd0, busy4}, 32'd0);
        chk_eq("rst_valid", {31'd0, cv4}, 32'd0);
        chk_eq("rst_crc_out", {28'd0, co4}, 32'd0);
        chk_eq("rst_match", {31'd0, cm4}, 32'd0);
        chk_eq("rst_len_err", {31'd0, le4}, 32'd0);
        chk_eq("rst_err_sync", {31'd0, es4}, 32'd0);
        chk_eq("rst6_crc_out", {26'd0, co6}, 32'd0);
        reset = 1'b0;
        idle(2);

        // CRC4 recommended, six zero nibbles; AUG then DONE after the eop.
        frm = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
        send(1'b0, 1'b1, 6'h05, 1'b1, 1'b0, 6'h05);
        idle(1);
        chk_eq("busy_in_aug", {31'd0, busy4}, 32'd1);
        idle(1);
        chk_eq("busy_in_done", {31'd0, busy4}, 32'd0);
        idle(2);

        // Same frame, legacy.
        send(1'b0, 1'b0, 6'h05, 1'b1, 1'b0, 6'h0F);
        idle(1);
        chk_eq("busy_legacy_done", {31'd0, busy4}, 32'd0);
        idle(2);

        // Single-chunk frames (sop+eop together).
        frm = '{6'h1};
        send(1'b0, 1'b1, 6'h07, 1'b1, 1'b0, 6'h07);
        idle(3);
        send(1'b0, 1'b0, 6'h07, 1'b1, 1'b0, 6'h02);
        idle(3);

        // CRC6 recommended, four zero chunks.
        frm = '{6'd0, 6'd0, 6'd0, 6'd0};
        send(1'b1, 1'b1, 6'h26, 1'b1, 1'b0, 6'h26);
        idle(4);
        rand_frame(5, 6);
        send(1'b1, 1'b0, 6'h00, 1'b1, 1'b1, 6'h00);
        idle(3);

        // Length boundary: eight chunks legal, nine flagged.
        rand_frame(8, 4);
        send(1'b0, 1'b0, 6'h03, 1'b1, 1'b1, 6'h00);
        idle(3);
        rand_frame(9, 4);
        send(1'b0, 1'b1, 6'h03, 1'b1, 1'b1, 6'h00);
        idle(4);
        rand_frame(12, 4);
        send(1'b0, 1'b0, 6'h0A, 1'b1, 1'b1, 6'h00);
        idle(3);

        // Data beat with no frame open: err_sync for exactly one cycle.
        @(negedge clk);
        v4 = 1'b1; sop4 = 1'b0; eop4 = 1'b1; din4 = 4'h3;
        idle(1);
        chk_eq("err_sync_pulse", {31'd0, es4}, 32'd1);
        chk_eq("err_sync_busy", {31'd0, busy4}, 32'd0);
        idle(1);
        chk_eq("err_sync_clear", {31'd0, es4}, 32'd0);
        idle(2);

        // New sop mid-frame: only the second frame reports.
        rand_frame(3, 4);
        send(1'b0, 1'b1, 6'h00, 1'b0, 1'b1, 6'h00);
        rand_frame(4, 4);
        send(1'b0, 1'b1, 6'h09, 1'b1, 1'b1, 6'h00);
        idle(4);

        // Reset mid-frame: outputs cleared, nothing reported.
        rand_frame(3, 4);
        send(1'b0, 1'b0, 6'h00, 1'b0, 1'b1, 6'h00);
        @(negedge clk);
        v4 = 1'b0; sop4 = 1'b0; eop4 = 1'b0;
        reset = 1'b1;
        #1;
        chk_eq("midrst_busy", {31'd0, busy4}, 32'd0);
        chk_eq("midrst_valid", {31'd0, cv4}, 32'd0);
        chk_eq("midrst_crc_out", {28'd0, co4}, 32'd0);
        chk_eq("midrst_match", {31'd0, cm4}, 32'd0);
        chk_eq("midrst_len_err", {31'd0, le4}, 32'd0);
        chk_eq("midrst_err_sync", {31'd0, es4}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        // The tail of the discarded frame is now an out-of-sync beat.
        @(negedge clk);
        v4 = 1'b1; sop4 = 1'b0; eop4 = 1'b1; din4 = 4'h6;
        idle(1);
        chk_eq("midrst_tail_err_sync", {31'd0, es4}, 32'd1);
        idle(3);

        // Back-to-back legacy frames: next sop lands in the DONE cycle.
        rand_frame(2, 4);
        send(1'b0, 1'b0, 6'h04, 1'b1, 1'b1, 6'h00);
        rand_frame(2, 4);
        send(1'b0, 1'b0, 6'h0B, 1'b1, 1'b1, 6'h00);
        rand_frame(3, 4);
        send(1'b0, 1'b0, 6'h01, 1'b1, 1'b1, 6'h00);
        idle(3);

        // A few random frames on both instances, either mode.
        for (int k = 0; k < 6; k++) begin
            rand_frame($urandom_range(8, 1), 4);
            send(1'b0, 1'($urandom_range(1, 0)), 6'($urandom_range(15, 0)), 1'b1, 1'b1, 6'h00);
            rand_frame($urandom_range(8, 1), 6);
            send(1'b1, 1'($urandom_range(1, 0)), 6'($urandom_range(63, 0)), 1'b1, 1'b1, 6'h00);
            idle(3);
        end

        idle(10);
        chk_eq("sb4_drained", sb4.size(), 32'd0);
        chk_eq("sb6_drained", sb6.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
